ctrl_pipe_carrier: RTL and testbench
====================================

Name: ctrl_pipe_carrier

Overview:
- Receiving end of the control-decoder bundle: EX[3:0], M[2:0], WB[1:0].
- Latches each bundle into ID/EX, advances it through EX/MEM and MEM/WB, and breaks it into named per-stage control lines for the datapath.
- Inserts bubbles for load-use stalls and squashes wrong-path instructions on a taken branch.
- Keeps retire and bubble counters for lab debug.

Parameters:
CNT_W, 16, width of retire_count and bubble_count

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ex_in  in  4  {RegDst, ALUOp[1:0], ALUSrc} from decoder
m_in  in  3  {Branch, MemRead, MemWrite} from decoder
wb_in  in  2  {RegWrite, MemtoReg} from decoder
valid_in  in  1  decoder bundle corresponds to a real instruction
stall  in  1  load-use hazard: hold ID, inject bubble into ID/EX
flush  in  1  branch taken in MEM: squash ID/EX and EX/MEM contents
ex_valid  out  1  ID/EX stage holds a real instruction
reg_dst  out  1  EX stage RegDst
alu_op  out  2  EX stage ALUOp
alu_src  out  1  EX stage ALUSrc
mem_valid  out  1  EX/MEM stage valid
branch  out  1  MEM stage Branch
mem_read  out  1  MEM stage MemRead
mem_write  out  1  MEM stage MemWrite
wb_valid  out  1  MEM/WB stage valid
reg_write  out  1  WB stage RegWrite
mem_to_reg  out  1  WB stage MemtoReg
retire_count  out  CNT_W  instructions leaving MEM/WB with wb_valid=1
bubble_count  out  CNT_W  bubbles injected by stall or flush

Behaviour:
- All state updates on rising clk.
- rst=1: every stage register, valid bit and counter goes to 0 on that edge, so all outputs are 0 the next cycle. Reset mid-stream discards all in-flight bundles.
- Capture sanitising: when wb_in[1]=0, RegDst and MemtoReg are forced to 0. This fixes the decoder's don't-care bits for SW and BEQ.
- Capture sanitising: valid_in=0 captures an all-zero bundle with valid=0.
- Latency: bundle present at edge N appears on EX outputs after N, MEM outputs after N+1, WB outputs after N+2.
- Each stage's outputs are driven directly from its register; no combinational input-to-output path.
- Normal cycle:
  - MEM/WB <= EX/MEM (M bits dropped).
  - EX/MEM <= ID/EX (EX bits dropped).
  - ID/EX <= sanitised input.
- stall=1, flush=0:
  - ID/EX <= all-zero, valid=0.
  - EX/MEM and MEM/WB advance normally.
  - bubble_count += 1.
  - The decoder holds its input; the same bundle is captured on the first non-stall edge.
- flush=1, regardless of stall:
  - ID/EX <= zero and EX/MEM <= zero, both valid=0.
  - MEM/WB still receives the old EX/MEM contents (the branch itself completes).
  - bubble_count += 2.
- Retire: retire_count += 1 on every edge where wb_valid=1 before the edge.
- Counters wrap modulo 2^CNT_W; no saturation.
- Combined edge: when a retire and a bubble increment occur on the same edge, both counters update independently.
- A zero bundle with valid_in=1 (NOP) is a real instruction. It carries valid and retires, but asserts no control lines.

Test Plan:
- R-type: ex_in=1100, m_in=000, wb_in=10, valid_in=1 for one cycle, then valid_in=0 → cycle+1 reg_dst=1, alu_op=10, alu_src=0; cycle+2 all M lines 0, mem_valid=1; cycle+3 reg_write=1, mem_to_reg=0; retire_count=1 after cycle+4.
- LW then SW with SW wb_in=0x (decoder X), sequence LW(0001/010/11), SW(x001/001/0x) → LW: alu_src=1, mem_read=1, reg_write=1, mem_to_reg=1. SW: reg_dst=0, mem_write=1, reg_write=0, mem_to_reg=0. No X on any output.
- Load-use: LW, then stall=1 for one cycle with ADD held, then ADD → EX outputs all 0 with ex_valid=0 for one cycle between LW and ADD; bubble_count=1; retire_count=2 after drain.
- Branch flush: BEQ(x010/100/0x), I1, I2 back-to-back, flush=1 when branch=1 → I1 and I2 never reach WB with valid; BEQ reaches wb_valid=1; bubble_count=2; retire_count=1.
- stall and flush on the same cycle → flush behaviour only; bubble_count increases by 2, not 3.
- Reset mid-stream: assert rst with 3 instructions in flight → next cycle every output and both counters 0; resumes cleanly with the next instruction.
- Wrap: CNT_W=4, retire 17 instructions → retire_count=1.

Source files
------------

// File: rtl/ctrl_pipe_carrier.sv
// rtl/ctrl_pipe_carrier.sv - ID/EX, EX/MEM, MEM/WB control carrier with bubble/squash and debug counters
// Outputs come straight from stage registers; the decoder bundle is sanitised on capture.
module ctrl_pipe_carrier #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ex_in,
  input  logic [2:0]       m_in,
  input  logic [1:0]       wb_in,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic             reg_dst,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             mem_valid,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_valid,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] bubble_count
);

  logic [3:0]       cap_ex;
  logic [2:0]       cap_m;
  logic [1:0]       cap_wb;
  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [1:0]       exmem_wb;
  logic [CNT_W-1:0] bubble_inc;
  logic [CNT_W-1:0] retire_inc;

  // Non-writing instructions leave RegDst/MemtoReg undefined at the decoder; pin them low.
  always_comb begin
    cap_ex = '0;
    cap_m  = '0;
    cap_wb = '0;
    if (valid_in) begin
      cap_ex = {ex_in[3] & wb_in[1], ex_in[2:0]};
      cap_m  = m_in;
      cap_wb = {wb_in[1], wb_in[0] & wb_in[1]};
    end
  end

  always_comb begin
    bubble_inc = '0;
    if (flush)
      bubble_inc = CNT_W'(2);
    else if (stall)
      bubble_inc = CNT_W'(1);
    retire_inc = {{(CNT_W-1){1'b0}}, wb_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      reg_dst      <= 1'b0;
      alu_op       <= 2'b00;
      alu_src      <= 1'b0;
      idex_m       <= 3'b000;
      idex_wb      <= 2'b00;
      mem_valid    <= 1'b0;
      branch       <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      exmem_wb     <= 2'b00;
      wb_valid     <= 1'b0;
      reg_write    <= 1'b0;
      mem_to_reg   <= 1'b0;
      retire_count <= '0;
      bubble_count <= '0;
    end else begin
      // MEM/WB always advances so a taken branch in MEM still completes.
      wb_valid   <= mem_valid;
      reg_write  <= exmem_wb[1];
      mem_to_reg <= exmem_wb[0];

      if (flush) begin
        mem_valid <= 1'b0;
        branch    <= 1'b0;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        exmem_wb  <= 2'b00;
      end else begin
        mem_valid <= ex_valid;
        branch    <= idex_m[2];
        mem_read  <= idex_m[1];
        mem_write <= idex_m[0];
        exmem_wb  <= idex_wb;
      end

      if (flush || stall) begin
        ex_valid <= 1'b0;
        reg_dst  <= 1'b0;
        alu_op   <= 2'b00;
        alu_src  <= 1'b0;
        idex_m   <= 3'b000;
        idex_wb  <= 2'b00;
      end else begin
        ex_valid <= valid_in;
        reg_dst  <= cap_ex[3];
        alu_op   <= cap_ex[2:1];
        alu_src  <= cap_ex[0];
        idex_m   <= cap_m;
        idex_wb  <= cap_wb;
      end

      retire_count <= retire_count + retire_inc;
      bubble_count <= bubble_count + bubble_inc;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_carrier.sv
// tb/tb_ctrl_pipe_carrier.sv - directed bench with a bundle-queue model and literal checkpoints
module tb_ctrl_pipe_carrier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] ex_in = '0;
  logic [2:0] m_in = '0;
  logic [1:0] wb_in = '0;
  logic       valid_in = 1'b0, stall = 1'b0, flush = 1'b0;

  logic        ex_valid, reg_dst, alu_src, mem_valid, branch, mem_read, mem_write;
  logic        wb_valid, reg_write, mem_to_reg;
  logic [1:0]  alu_op;
  logic [15:0] retire_count, bubble_count;

  logic        ex_valid4, reg_dst4, alu_src4, mem_valid4, branch4, mem_read4, mem_write4;
  logic        wb_valid4, reg_write4, mem_to_reg4;
  logic [1:0]  alu_op4;
  logic [3:0]  retire_count4, bubble_count4;

  ctrl_pipe_carrier dut (
    .clk(clk), .rst(rst), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .reg_dst(reg_dst), .alu_op(alu_op), .alu_src(alu_src),
    .mem_valid(mem_valid), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .wb_valid(wb_valid), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .retire_count(retire_count), .bubble_count(bubble_count)
  );

  ctrl_pipe_carrier #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .ex_valid(ex_valid4), .reg_dst(reg_dst4), .alu_op(alu_op4), .alu_src(alu_src4),
    .mem_valid(mem_valid4), .branch(branch4), .mem_read(mem_read4), .mem_write(mem_write4),
    .wb_valid(wb_valid4), .reg_write(reg_write4), .mem_to_reg(mem_to_reg4),
    .retire_count(retire_count4), .bubble_count(bubble_count4)
  );

  int errors = 0;
  int checks = 0;

  // Model: an instruction is a full sanitised bundle; stages are slots it moves through.
  typedef struct packed {
    logic       v;
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
  } bundle_t;

  bundle_t slot[3];
  int      m_retired = 0;
  int      m_bubbles = 0;
  bit      chk_en = 1'b0;

  function automatic bundle_t sanitise();
    bundle_t b;
    b = '0;
    if (valid_in) begin
      b.v  = 1'b1;
      b.ex = {(wb_in[1] ? ex_in[3] : 1'b0), ex_in[2:0]};
      b.m  = m_in;
      b.wb = {wb_in[1], (wb_in[1] ? wb_in[0] : 1'b0)};
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) slot[i] = '0;
      m_retired = 0;
      m_bubbles = 0;
    end else begin
      if (slot[2].v) m_retired++;
      m_bubbles += flush ? 2 : (stall ? 1 : 0);
      slot[2] = slot[1];
      slot[1] = flush ? '0 : slot[0];
      slot[0] = (flush || stall) ? '0 : sanitise();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("stages16",
          {ex_valid, reg_dst, alu_op, alu_src, mem_valid, branch, mem_read, mem_write,
           wb_valid, reg_write, mem_to_reg},
          {slot[0].v, slot[0].ex, slot[1].v, slot[1].m, slot[2].v, slot[2].wb});
      chk("stages4",
          {ex_valid4, reg_dst4, alu_op4, alu_src4, mem_valid4, branch4, mem_read4, mem_write4,
           wb_valid4, reg_write4, mem_to_reg4},
          {slot[0].v, slot[0].ex, slot[1].v, slot[1].m, slot[2].v, slot[2].wb});
      chk("counters16", {retire_count, bubble_count},
          {m_retired[15:0], m_bubbles[15:0]});
      chk("counters4", {retire_count4, bubble_count4},
          {m_retired[3:0], m_bubbles[3:0]});
    end
  end

  task automatic cyc(input logic v, input logic [3:0] e, input logic [2:0] mm,
                     input logic [1:0] w, input logic s, input logic f);
    @(negedge clk);
    valid_in = v; ex_in = e; m_in = mm; wb_in = w; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 3'h0, 2'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset_all", {ex_valid, reg_dst, alu_op, alu_src, mem_valid, branch, mem_read,
                      mem_write, wb_valid, reg_write, mem_to_reg, retire_count, bubble_count}, 0);

    // R-type
    cyc(1'b1, 4'b1100, 3'b000, 2'b10, 1'b0, 1'b0);
    chk("rtype_ex", {ex_valid, reg_dst, alu_op, alu_src}, 5'b11100);
    idle(1);
    chk("rtype_mem", {mem_valid, branch, mem_read, mem_write}, 4'b1000);
    idle(1);
    chk("rtype_wb", {wb_valid, reg_write, mem_to_reg}, 3'b110);
    idle(1);
    chk("rtype_retire", retire_count, 1);

    // LW then SW with undefined decoder bits
    do_reset();
    cyc(1'b1, 4'b0001, 3'b010, 2'b11, 1'b0, 1'b0);
    chk("lw_ex", {reg_dst, alu_src}, 2'b01);
    cyc(1'b1, 4'bx001, 3'b001, 2'b0x, 1'b0, 1'b0);
    chk("sw_ex", {ex_valid, reg_dst, alu_src}, 3'b101);
    chk("lw_mem", {mem_read, mem_write}, 2'b10);
    idle(1);
    chk("sw_mem", {mem_read, mem_write}, 2'b01);
    chk("lw_wb", {reg_write, mem_to_reg}, 2'b11);
    idle(1);
    chk("sw_wb", {wb_valid, reg_write, mem_to_reg}, 3'b100);
    chk("sw_no_x", 32'($isunknown({reg_dst, alu_op, alu_src, mem_read, mem_write,
                                   reg_write, mem_to_reg})), 0);

    // Load-use stall
    do_reset();
    cyc(1'b1, 4'b0001, 3'b010, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 4'b1100, 3'b000, 2'b10, 1'b1, 1'b0);
    chk("stall_bubble_ex", {ex_valid, reg_dst, alu_op, alu_src}, 0);
    chk("stall_bubble_cnt", bubble_count, 1);
    cyc(1'b1, 4'b1100, 3'b000, 2'b10, 1'b0, 1'b0);
    chk("stall_add_ex", {ex_valid, reg_dst, alu_op}, 4'b1110);
    idle(3);
    chk("stall_retire", retire_count, 2);

    // Branch flush, then again with stall on the same edge
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cyc(1'b1, 4'bx010, 3'b100, 2'b0x, 1'b0, 1'b0);
      cyc(1'b1, 4'b1100, 3'b000, 2'b10, 1'b0, 1'b0);
      chk("br_in_mem", {mem_valid, branch}, 2'b11);
      cyc(1'b1, 4'b0001, 3'b010, 2'b11, (k == 1), 1'b1);
      chk("br_flushed", {ex_valid, mem_valid, wb_valid}, 3'b001);
      chk("br_bubbles", bubble_count, 2);
      idle(3);
      chk("br_retire", retire_count, 1);
      chk("br_bubbles_final", bubble_count, 2);
    end

    // Reset with instructions in flight
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1100, 3'b000, 2'b10, (i == 1), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    chk("midrst_all", {ex_valid, reg_dst, alu_op, alu_src, mem_valid, branch, mem_read,
                       mem_write, wb_valid, reg_write, mem_to_reg, retire_count, bubble_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 4'b0001, 3'b010, 2'b11, 1'b0, 1'b0);
    idle(3);
    chk("midrst_resume", {retire_count, bubble_count}, {16'd1, 16'd0});

    // Counter wrap with NOPs (valid zero bundles)
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 4'h0, 3'h0, 2'h0, 1'b0, 1'b0);
    idle(3);
    chk("wrap_retire4", retire_count4, 1);
    chk("wrap_retire16", retire_count, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
